// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port (WE3/A3/WD3) between the
//   pipeline writeback stage and a long-latency multi-cycle unit (mul/div).
//   Multi-cycle results are parked in a one-entry buffer. The buffer drains
//   whenever writeback is idle. A bounded-wait counter forces the buffer
//   through after MAX_WAIT lost cycles, stalling writeback for one cycle.
//
//   Optional feature, macro RF_ARB_CLEAR_EN: after reset a sequencer writes
//   zero to x1..x31, one register per cycle, while busy is held high.
//
// Parameters
//   MAX_WAIT  cycles a buffered result may lose to writeback (1..15)
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   wb_we      writeback write request
//   wb_rd      writeback destination register
//   wb_data    writeback data
//   mc_valid   multi-cycle result valid
//   mc_rd      multi-cycle destination register
//   mc_data    multi-cycle result data
//   mc_ready   buffer can accept a multi-cycle result
//   rf_we      register-file write enable (WE3)
//   rf_a3      register-file write address (A3)
//   rf_wd      register-file write data (WD3)
//   wb_stall   writeback refused this cycle
//   busy       post-reset clear in progress
module rf_write_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        wb_stall,
  output logic        busy
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic        clearing;
  logic [4:0]  clr_a3;

`ifdef RF_ARB_CLEAR_EN
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= 5'd1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // One register cleared per cycle; leave CLEAR right after writing x31.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31) begin
        state_d = S_RUN;
      end
    end
  end

  assign clearing = (state_q == S_CLEAR);
  assign clr_a3   = clr_idx_q;
`else
  assign clearing = 1'b0;
  assign clr_a3   = 5'd0;
`endif

  logic run;
  logic wb_req;
  logic force_drain;

  // Outputs are gated by rst so the port stays quiet while reset is held.
  assign run         = rst & ~clearing;
  assign busy        = clearing;
  assign mc_ready    = run & ~buf_valid_q;
  assign wb_req      = wb_we & (wb_rd != 5'd0);
  assign force_drain = buf_valid_q & (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    rf_we       = 1'b0;
    rf_a3       = 5'd0;
    rf_wd       = 32'd0;
    wb_stall    = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    wait_cnt_d  = wait_cnt_q;

    if (rst && clearing) begin
      rf_we = 1'b1;
      rf_a3 = clr_a3;
    end else if (run) begin
      // Accept and drain are exclusive: mc_ready requires an empty buffer.
      if (mc_valid && mc_ready) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = mc_rd;
        buf_data_d  = mc_data;
        wait_cnt_d  = 4'd0;
      end

      if (buf_valid_q && (!wb_req || force_drain)) begin
        // An entry for x0 drains silently.
        rf_we       = (buf_rd_q != 5'd0);
        rf_a3       = buf_rd_q;
        rf_wd       = buf_data_q;
        buf_valid_d = 1'b0;
        wait_cnt_d  = 4'd0;
      end else if (wb_req) begin
        rf_we = 1'b1;
        rf_a3 = wb_rd;
        rf_wd = wb_data;
        if (buf_valid_q && (wait_cnt_q != MAX_WAIT_C)) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      wb_stall = force_drain & wb_req;
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      wait_cnt_q  <= 4'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Buffer payload; only meaningful while buf_valid_q is set.
  always_ff @(posedge clk) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        wb_stall;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef RF_ARB_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        stall;
  } wr_t;

  wr_t exp_q[$];

  rf_write_arbiter #(.MAX_WAIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .mc_valid (mc_valid),
    .mc_rd    (mc_rd),
    .mc_data  (mc_data),
    .mc_ready (mc_ready),
    .rf_we    (rf_we),
    .rf_a3    (rf_a3),
    .rf_wd    (rf_wd),
    .wb_stall (wb_stall),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a3, input logic [31:0] wd, input logic stall);
    wr_t e;
    e.a3    = a3;
    e.wd    = wd;
    e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write presented on the port must match the next expected write.
  always @(negedge clk) begin
    if (rst && rf_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got a3=%0d wd=%h, none expected", rf_a3, rf_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_a3", 32'(rf_a3), 32'(e.a3));
        chk("write_wd", rf_wd, e.wd);
        chk("write_stall", 32'(wb_stall), 32'(e.stall));
      end
    end
  end

  // Called one time unit after a rising edge; releases reset and walks the clear.
  task automatic release_rst();
`ifdef RF_ARB_CLEAR_EN
    for (int i = 1; i < 32; i++) push(5'(i), 32'd0, 1'b0);
`endif
    rst = 1'b1;
`ifdef RF_ARB_CLEAR_EN
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("clear_busy", 32'(busy), 32'd1);
      chk("clear_mc_ready", 32'(mc_ready), 32'd0);
    end
`endif
    @(negedge clk);
    chk("busy_after_clear", 32'(busy), 32'd0);
    chk("mc_ready_after_clear", 32'(mc_ready), 32'd1);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_rf_a3"}, 32'(rf_a3), 32'd0);
    chk({tag, "_rf_wd"}, rf_wd, 32'd0);
    chk({tag, "_mc_ready"}, 32'(mc_ready), 32'd0);
    chk({tag, "_wb_stall"}, 32'(wb_stall), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'(BUSY_RST));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    wb_we    = 1'b1;   // requests during reset must be ignored
    wb_rd    = 5'd3;
    wb_data  = 32'hCAFE0000;
    mc_valid = 1'b1;
    mc_rd    = 5'd6;
    mc_data  = 32'h66;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk_reset_outputs("reset");
    step();
    wb_we    = 1'b0;
    mc_valid = 1'b0;
    release_rst();

    // Idle port: accept, then write one cycle later
    mc_valid = 1'b1;
    mc_rd    = 5'd5;
    mc_data  = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("idle_ready_before", 32'(mc_ready), 32'd1);
    step();
    mc_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready_held", 32'(mc_ready), 32'd0);
    chk("idle_rf_we", 32'(rf_we), 32'd1);
    step();
    @(negedge clk);
    chk("idle_ready_after", 32'(mc_ready), 32'd1);
    step();

    // Starvation bound with MAX_WAIT=4
    mc_valid = 1'b1;
    mc_rd    = 5'd7;
    mc_data  = 32'h00000077;
    step();
    mc_valid = 1'b0;
    for (int c = 0; c < 4; c++) push(5'd3, 32'h300 + 32'(c), 1'b0);
    push(5'd7, 32'h77, 1'b1);
    push(5'd3, 32'h304, 1'b0);
    wb_we = 1'b1;
    wb_rd = 5'd3;
    for (int c = 0; c < 6; c++) begin
      wb_data = (c < 5) ? 32'h300 + 32'(c) : 32'h304;
      @(negedge clk);
      chk("starve_wb_stall", 32'(wb_stall), (c == 4) ? 32'd1 : 32'd0);
      step();
    end
    wb_we = 1'b0;
    step();

    // x0 filtering: writeback to x0
    wb_we   = 1'b1;
    wb_rd   = 5'd0;
    wb_data = 32'h12345678;
    @(negedge clk);
    chk("wb_x0_rf_we", 32'(rf_we), 32'd0);
    step();
    wb_we = 1'b0;

    // x0 filtering: buffered entry to x0 drains silently in one cycle
    mc_valid = 1'b1;
    mc_rd    = 5'd0;
    mc_data  = 32'hAAAA5555;
    step();
    mc_valid = 1'b0;
    @(negedge clk);
    chk("mc_x0_rf_we", 32'(rf_we), 32'd0);
    chk("mc_x0_ready_busy", 32'(mc_ready), 32'd0);
    step();
    @(negedge clk);
    chk("mc_x0_drained", 32'(mc_ready), 32'd1);
    step();

    // WB to x0 does not block the buffer
    mc_valid = 1'b1;
    mc_rd    = 5'd9;
    mc_data  = 32'h00000099;
    step();
    mc_valid = 1'b0;
    wb_we    = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'h55;
    push(5'd9, 32'h99, 1'b0);
    @(negedge clk);
    chk("x0wb_stall", 32'(wb_stall), 32'd0);
    chk("x0wb_rf_a3", 32'(rf_a3), 32'd9);
    step();
    wb_we = 1'b0;
    @(negedge clk);
    chk("x0wb_ready_after", 32'(mc_ready), 32'd1);
    step();

    // Reset mid-operation: buffer holds x4 with wait_cnt=2
    mc_valid = 1'b1;
    mc_rd    = 5'd4;
    mc_data  = 32'h00000044;
    step();
    mc_valid = 1'b0;
    wb_we    = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'h310;
    push(5'd3, 32'h310, 1'b0);
    step();
    wb_data = 32'h311;
    push(5'd3, 32'h311, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    step();
    wb_we = 1'b0;
    release_rst();
    repeat (6) step();
    @(negedge clk);
    chk("midrst_no_x4_ready", 32'(mc_ready), 32'd1);
    chk("expected_writes_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
